// File: rtl/mm_uart_pkg.sv
// Shared constants for the memory-mapped UART responder: register offsets,
// STATUS bit positions and the 2-bit TX/RX FSM state encodings.
// No logic lives here apart from the DIV clamp helper.
package mm_uart_pkg;

   // Register offsets within the 4-word window (addr[1:0])
   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;
   localparam logic [1:0] OFF_CLR    = 2'd3;

   // STATUS bit positions
   localparam int ST_RX_AVAIL   = 0;
   localparam int ST_TX_READY   = 1;
   localparam int ST_TX_IDLE    = 2;
   localparam int ST_RX_OVERRUN = 3;
   localparam int ST_FRAME_ERR  = 4;
   localparam int ST_TX_DROP    = 5;
   localparam int ST_RX_CNT_LSB = 8;
   localparam int ST_TX_CNT_LSB = 12;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // A bit period below 2 would make the half-period START wait zero cycles
   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < 16'd2) ? 16'd2 : v;
   endfunction

endpackage

// File: rtl/mm_sync_fifo.sv
// Small synchronous FIFO with combinational head, used for UART TX and RX bytes.
// Latency: a push is visible at head/count on the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module mm_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pop of an empty FIFO is a no-op; a full FIFO still accepts a push when
   // the head leaves in the same cycle
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mm_uart_resp.sv
// Memory-mapped UART target: 4-register window, 8N1 TX/RX with byte FIFOs.
// Latency: rdata is combinational with mm_re; TX line drops one edge after a DATA write.
// Backpressure: none on the bus; full TX FIFO drops and flags, full RX FIFO flags overrun.
module mm_uart_resp
   import mm_uart_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR   = 16'hC000,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic        mm_we,
   input  logic        mm_re,
   output logic [15:0] rdata,
   output logic        tx,
   input  logic        rx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // ---------------- bus decode ----------------
   logic       sel;
   logic       wr;
   logic       rd;
   logic [1:0] off;
   logic       wr_data;
   logic       wr_div;
   logic       wr_clr;
   logic       rd_data;

   assign sel     = (addr[15:2] == BASE_ADDR[15:2]);
   assign off     = addr[1:0];
   assign wr      = mm_we && sel;
   assign rd      = mm_re && sel;
   assign wr_data = wr && (off == OFF_DATA);
   assign wr_div  = wr && (off == OFF_DIV);
   assign wr_clr  = wr && (off == OFF_CLR);
   assign rd_data = rd && (off == OFF_DATA);

   logic [15:0] div_q;
   logic        rx_overrun;
   logic        frame_err;
   logic        tx_drop;

   // ---------------- FIFOs ----------------
   logic          tx_pop;
   logic [7:0]    tx_head;
   logic [CW-1:0] tx_count;
   logic          tx_full;
   logic          tx_empty;

   logic          rx_push;
   logic [7:0]    rx_head;
   logic [CW-1:0] rx_count;
   logic          rx_full;
   logic          rx_empty;
   logic [7:0]    rx_sh;

   mm_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_data),
      .din   (wdata[7:0]),
      .pop   (tx_pop),
      .head  (tx_head),
      .count (tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   mm_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push),
      .din   (rx_sh),
      .pop   (rd_data),
      .head  (rx_head),
      .count (rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // ---------------- TX path ----------------
   tx_state_t   tx_state;
   tx_state_t   tx_state_nxt;
   logic [15:0] tx_cnt;
   logic [15:0] tx_cnt_nxt;
   logic [7:0]  tx_sh;
   logic [7:0]  tx_sh_nxt;
   logic [2:0]  tx_bit;
   logic [2:0]  tx_bit_nxt;
   logic        tx_idle;

   // TX next state: each state lasts DIV cycles, counter reloads from the
   // current DIV at every bit boundary; STOP chains straight into START
   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_nxt   = tx_cnt;
      tx_sh_nxt    = tx_sh;
      tx_bit_nxt   = tx_bit;
      tx_pop       = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_state_nxt = TX_START;
               tx_pop       = 1'b1;
               tx_sh_nxt    = tx_head;
               tx_cnt_nxt   = div_q - 16'd1;
            end
         end
         TX_START: begin
            if (tx_cnt == '0) begin
               tx_state_nxt = TX_DATA;
               tx_bit_nxt   = 3'd0;
               tx_cnt_nxt   = div_q - 16'd1;
            end else begin
               tx_cnt_nxt = tx_cnt - 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_cnt == '0) begin
               tx_cnt_nxt = div_q - 16'd1;
               if (tx_bit == 3'd7) begin
                  tx_state_nxt = TX_STOP;
               end else begin
                  tx_bit_nxt = tx_bit + 3'd1;
                  tx_sh_nxt  = {1'b0, tx_sh[7:1]};
               end
            end else begin
               tx_cnt_nxt = tx_cnt - 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_cnt == '0) begin
               if (!tx_empty) begin
                  tx_state_nxt = TX_START;
                  tx_pop       = 1'b1;
                  tx_sh_nxt    = tx_head;
                  tx_cnt_nxt   = div_q - 16'd1;
               end else begin
                  tx_state_nxt = TX_IDLE;
               end
            end else begin
               tx_cnt_nxt = tx_cnt - 16'd1;
            end
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   // TX state register and shifter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_sh    <= '0;
         tx_bit   <= '0;
      end else begin
         tx_state <= tx_state_nxt;
         tx_cnt   <= tx_cnt_nxt;
         tx_sh    <= tx_sh_nxt;
         tx_bit   <= tx_bit_nxt;
      end
   end

   // Line level decoded from state so reset forces it high without a clock
   always_comb begin
      case (tx_state)
         TX_START: tx = 1'b0;
         TX_DATA:  tx = tx_sh[0];
         default:  tx = 1'b1;
      endcase
   end

   assign tx_idle = tx_empty && (tx_state == TX_IDLE);

   // ---------------- RX path ----------------
   logic        rx_s1;
   logic        rx_s2;
   logic        rx_prev;
   logic        rx_fall;
   rx_state_t   rx_state;
   rx_state_t   rx_state_nxt;
   logic [15:0] rx_cnt;
   logic [15:0] rx_cnt_nxt;
   logic [7:0]  rx_sh_nxt;
   logic [2:0]  rx_bit;
   logic [2:0]  rx_bit_nxt;
   logic        rx_brk;
   logic        rx_brk_nxt;
   logic        frame_set;
   logic        overrun_set;

   // Two-flop synchroniser plus one more stage for falling-edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign rx_fall = rx_prev && !rx_s2;

   // RX next state: half-period START check, 8 samples at DIV spacing, then a
   // stop sample; a bad stop bit holds in STOP until the line returns high
   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = rx_cnt;
      rx_sh_nxt    = rx_sh;
      rx_bit_nxt   = rx_bit;
      rx_brk_nxt   = rx_brk;
      rx_push      = 1'b0;
      frame_set    = 1'b0;
      overrun_set  = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_fall) begin
               rx_state_nxt = RX_START;
               rx_cnt_nxt   = (div_q >> 1) - 16'd1;
            end
         end
         RX_START: begin
            if (rx_cnt == '0) begin
               if (rx_s2) begin
                  rx_state_nxt = RX_IDLE;
               end else begin
                  rx_state_nxt = RX_DATA;
                  rx_bit_nxt   = 3'd0;
                  rx_cnt_nxt   = div_q - 16'd1;
               end
            end else begin
               rx_cnt_nxt = rx_cnt - 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_cnt == '0) begin
               rx_sh_nxt  = {rx_s2, rx_sh[7:1]};
               rx_cnt_nxt = div_q - 16'd1;
               if (rx_bit == 3'd7) begin
                  rx_state_nxt = RX_STOP;
               end else begin
                  rx_bit_nxt = rx_bit + 3'd1;
               end
            end else begin
               rx_cnt_nxt = rx_cnt - 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_brk) begin
               if (rx_s2) begin
                  rx_brk_nxt   = 1'b0;
                  rx_state_nxt = RX_IDLE;
               end
            end else if (rx_cnt == '0) begin
               if (!rx_s2) begin
                  frame_set  = 1'b1;
                  rx_brk_nxt = 1'b1;
               end else begin
                  rx_state_nxt = RX_IDLE;
                  rx_push      = 1'b1;
                  overrun_set  = rx_full && !rd_data;
               end
            end else begin
               rx_cnt_nxt = rx_cnt - 16'd1;
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // RX state register and shifter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_sh    <= '0;
         rx_bit   <= '0;
         rx_brk   <= 1'b0;
      end else begin
         rx_state <= rx_state_nxt;
         rx_cnt   <= rx_cnt_nxt;
         rx_sh    <= rx_sh_nxt;
         rx_bit   <= rx_bit_nxt;
         rx_brk   <= rx_brk_nxt;
      end
   end

   // ---------------- registers ----------------
   logic [2:0] clr;
   logic       drop_set;

   assign clr      = wr_clr ? wdata[2:0] : 3'b000;
   assign drop_set = wr_data && tx_full && !tx_pop;

   // DIV register and sticky flags; a set in the same cycle as CLR wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= DEFAULT_DIV;
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
         tx_drop    <= 1'b0;
      end else begin
         if (wr_div) div_q <= clamp_div(wdata);
         rx_overrun <= overrun_set | (rx_overrun & ~clr[0]);
         frame_err  <= frame_set   | (frame_err  & ~clr[1]);
         tx_drop    <= drop_set    | (tx_drop    & ~clr[2]);
      end
   end

   logic [15:0] status;

   // STATUS word assembly
   always_comb begin
      status                              = '0;
      status[ST_RX_AVAIL]                 = !rx_empty;
      status[ST_TX_READY]                 = !tx_full;
      status[ST_TX_IDLE]                  = tx_idle;
      status[ST_RX_OVERRUN]               = rx_overrun;
      status[ST_FRAME_ERR]                = frame_err;
      status[ST_TX_DROP]                  = tx_drop;
      status[ST_RX_CNT_LSB +: 4]          = 4'(rx_count);
      status[ST_TX_CNT_LSB +: 4]          = 4'(tx_count);
   end

   // Combinational read mux; reflects state before any same-cycle write
   always_comb begin
      rdata = '0;
      if (rd) begin
         case (off)
            OFF_DATA:   rdata = rx_empty ? 16'h0000 : {8'h00, rx_head};
            OFF_STATUS: rdata = status;
            OFF_DIV:    rdata = div_q;
            OFF_CLR:    rdata = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_mm_uart_resp.sv
// Directed bench for mm_uart_resp: register access, TX framing and queueing,
// RX framing with error cases, address decode and asynchronous reset.
// Expected values are hand-computed constants.
module tb_mm_uart_resp;

   localparam logic [15:0] A_DATA = 16'hC000;
   localparam logic [15:0] A_STAT = 16'hC001;
   localparam logic [15:0] A_DIV  = 16'hC002;
   localparam logic [15:0] A_CLR  = 16'hC003;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        mm_we;
   logic        mm_re;
   logic [15:0] rdata;
   logic        tx;
   logic        rx;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mm_uart_resp dut (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr),
      .wdata (wdata),
      .mm_we (mm_we),
      .mm_re (mm_re),
      .rdata (rdata),
      .tx    (tx),
      .rx    (rx)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [15:0] w);
      @(negedge clk);
      addr = a; wdata = w; mm_we = 1'b1;
      @(posedge clk); #1;
      mm_we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
      @(negedge clk);
      addr = a; mm_re = 1'b1;
      #1 d = rdata;
      @(posedge clk); #1;
      mm_re = 1'b0; addr = 16'h0000;
   endtask

   task automatic bus_rw(input logic [15:0] a, input logic [15:0] w, output logic [15:0] d);
      @(negedge clk);
      addr = a; wdata = w; mm_we = 1'b1; mm_re = 1'b1;
      #1 d = rdata;
      @(posedge clk); #1;
      mm_we = 1'b0; mm_re = 1'b0; addr = 16'h0000; wdata = 16'h0000;
   endtask

   // One 8N1 frame at 8 cycles per bit followed by idle line
   task automatic send_rx(input logic [7:0] b, input logic stopb);
      @(negedge clk);
      rx = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (8) @(negedge clk);
      end
      rx = stopb;
      repeat (8) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   logic [15:0] d;
   logic [9:0]  frame;
   logic        line_bits [50];
   logic [7:0]  qbytes [6];

   initial begin
      rst_n = 1'b0; addr = '0; wdata = '0; mm_we = 1'b0; mm_re = 1'b0; rx = 1'b1;
      qbytes[0] = 8'hA1; qbytes[1] = 8'hB2; qbytes[2] = 8'hC3;
      qbytes[3] = 8'hD4; qbytes[4] = 8'hE5; qbytes[5] = 8'hF6;
      repeat (3) @(negedge clk);
      chk("rst_tx", {15'd0, tx}, 16'h0001);
      rst_n = 1'b1;

      // reset state
      bus_rd(A_STAT, d); chk("rst_status", d, 16'h0006);
      bus_rd(A_DIV, d);  chk("rst_div", d, 16'd434);
      bus_rd(A_DATA, d); chk("rd_empty", d, 16'h0000);
      bus_rd(A_STAT, d); chk("rd_empty_status", d, 16'h0006);
      bus_rd(A_CLR, d);  chk("rd_clr", d, 16'h0000);

      // DIV clamp and simultaneous read/write
      bus_wr(A_DIV, 16'd1); bus_rd(A_DIV, d); chk("div_clamp1", d, 16'd2);
      bus_wr(A_DIV, 16'd0); bus_rd(A_DIV, d); chk("div_clamp0", d, 16'd2);
      bus_rw(A_DIV, 16'd4, d); chk("rw_pre", d, 16'd2);
      bus_rd(A_DIV, d); chk("rw_post", d, 16'd4);

      // single TX frame 0x55 at DIV=4
      bus_wr(A_DATA, 16'h0055);
      chk("tx_pre_start", {15'd0, tx}, 16'h0001);
      @(posedge clk); #1;
      chk("tx_start_low", {15'd0, tx}, 16'h0000);
      for (int k = 0; k < 10; k++) begin
         repeat (2) @(posedge clk); #1;
         frame[k] = tx;
         repeat (2) @(posedge clk);
      end
      chk("tx_frame55", {6'd0, frame}, {6'd0, 1'b1, 8'h55, 1'b0});
      bus_rd(A_STAT, d); chk("tx_idle_after", d, 16'h0006);

      // six back-to-back writes: five frames contiguous, sixth dropped
      fork
         begin
            for (int j = 0; j < 6; j++) bus_wr(A_DATA, {8'h00, qbytes[j]});
         end
         begin
            repeat (4) @(posedge clk); #1;
            line_bits[0] = tx;
            for (int k = 1; k < 50; k++) begin
               repeat (4) @(posedge clk); #1;
               line_bits[k] = tx;
            end
         end
      join
      for (int j = 0; j < 5; j++) begin
         for (int k = 0; k < 10; k++) frame[k] = line_bits[10*j + k];
         chk($sformatf("txq_frame%0d", j), {6'd0, frame}, {6'd0, 1'b1, qbytes[j], 1'b0});
      end
      repeat (4) @(posedge clk);
      bus_rd(A_STAT, d); chk("txq_drop", d, 16'h0026);
      bus_wr(A_CLR, 16'h0004);
      bus_rd(A_STAT, d); chk("txq_clr", d, 16'h0006);

      // RX good frame at DIV=8
      bus_wr(A_DIV, 16'd8);
      send_rx(8'hA3, 1'b1);
      bus_rd(A_STAT, d); chk("rx_status", d, 16'h0107);
      bus_rd(A_DATA, d); chk("rx_data", d, 16'h00A3);
      bus_rd(A_STAT, d); chk("rx_popped", d, 16'h0006);

      // framing error
      send_rx(8'h5C, 1'b0);
      bus_rd(A_STAT, d); chk("rx_frame_err", d, 16'h0016);
      bus_wr(A_CLR, 16'h0002);
      bus_rd(A_STAT, d); chk("rx_frame_clr", d, 16'h0006);

      // overrun: five frames, four stored
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      send_rx(8'h33, 1'b1);
      send_rx(8'h44, 1'b1);
      send_rx(8'h55, 1'b1);
      bus_rd(A_STAT, d); chk("rx_overrun", d, 16'h040F);
      bus_rd(A_DATA, d); chk("rx_q0", d, 16'h0011);
      bus_rd(A_DATA, d); chk("rx_q1", d, 16'h0022);
      bus_rd(A_DATA, d); chk("rx_q2", d, 16'h0033);
      bus_rd(A_DATA, d); chk("rx_q3", d, 16'h0044);
      bus_rd(A_STAT, d); chk("rx_ovr_sticky", d, 16'h000E);
      bus_wr(A_CLR, 16'h0001);
      bus_rd(A_STAT, d); chk("rx_ovr_clr", d, 16'h0006);

      // two-cycle glitch is rejected
      @(negedge clk); rx = 1'b0;
      repeat (2) @(negedge clk); rx = 1'b1;
      repeat (40) @(negedge clk);
      bus_rd(A_STAT, d); chk("rx_glitch", d, 16'h0006);

      // decode: outside window, STATUS write, mm_re low
      bus_wr(16'hC004, 16'h00FF);
      bus_wr(A_STAT, 16'hFFFF);
      bus_rd(16'hC005, d); chk("dec_outside", d, 16'h0000);
      repeat (3) @(posedge clk); #1;
      chk("dec_tx_high", {15'd0, tx}, 16'h0001);
      bus_rd(A_STAT, d); chk("dec_status", d, 16'h0006);
      @(negedge clk); addr = A_STAT; #1;
      chk("dec_no_re", rdata, 16'h0000);
      addr = 16'h0000;

      // asynchronous reset during a TX data bit
      bus_wr(A_DIV, 16'd4);
      bus_wr(A_DATA, 16'h0000);
      repeat (6) @(posedge clk); #1;
      chk("rst_mid_low", {15'd0, tx}, 16'h0000);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_tx", {15'd0, tx}, 16'h0001);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus_rd(A_STAT, d); chk("rst2_status", d, 16'h0006);
      bus_rd(A_DIV, d);  chk("rst2_div", d, 16'd434);
      repeat (10) @(posedge clk); #1;
      chk("rst2_tx", {15'd0, tx}, 16'h0001);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
